unidade_controle: RTL

- Multicycle control FSM driving the execute unit: generates estado, alusrc, alucontrol, branch, negativo and immediate for the ALU, plus register-file, memory, IR and PC strobes.
- Consumes the 32-bit instruction word from the instruction register.
- Supports the RV32I subset add, sub, and, or, xor, srl, addi, lw, sw, beq and bne.
- Counts retired instructions.

---
 rtl/unidade_controle.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Multicycle control FSM for an RV32I subset: decodes the IR word and sequences the execute unit.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal decodes park the FSM in TRAP instead of retiring as a NOP.
module unidade_controle #(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instruction,
    output logic [3:0]           estado,
    output logic                 alusrc,
    output logic [3:0]           alucontrol,
    output logic                 branch,
    output logic                 negativo,
    output logic [11:0]          immediate,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 pcwrite,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        StRstIdle = 4'b1110,
        StFetch   = 4'b0000,
        StDecode  = 4'b0001,
        StExec    = 4'b0101,
        StExecBr  = 4'b0110,
        StMemRd   = 4'b0111,
        StMemWr   = 4'b1000,
        StWbAlu   = 4'b1001,
        StWbMem   = 4'b1010,
        StBrRes   = 4'b1011,
        StTrap    = 4'b1111
    } state_e;

    typedef enum logic [1:0] {ClsAlu, ClsLoad, ClsStore, ClsBranch} cls_e;

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;

    logic                 alusrc_q, alusrc_d, branch_q, branch_d, negativo_q, negativo_d;
    logic [3:0]           alucontrol_q, alucontrol_d;
    logic [11:0]          immediate_q, immediate_d;
    logic                 irwrite_q, irwrite_d, regwrite_q, regwrite_d;
    logic                 memread_q, memread_d, memwrite_q, memwrite_d;
    logic                 memtoreg_q, memtoreg_d, pcwrite_q, pcwrite_d, illegal_q, illegal_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    // Combinational decode of the word presented during DECODE
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [11:0] field_i, field_s, field_b, mag_i, mag_s, mag_b;
    logic        dec_legal, dec_alusrc, dec_branch, dec_neg;
    logic [3:0]  dec_ctl;
    logic [11:0] dec_imm;
    cls_e        dec_cls;
    logic        unused_rs1;

    assign opcode     = instruction[6:0];
    assign funct3     = instruction[14:12];
    assign funct7     = instruction[31:25];
    assign unused_rs1 = ^instruction[19:15];
    assign field_i    = instruction[31:20];
    assign field_s    = {instruction[31:25], instruction[11:7]};
    // Branch offset with its always-zero LSB dropped, i.e. offset >> 1 in two's complement
    assign field_b    = {instruction[31], instruction[7], instruction[30:25], instruction[11:8]};
    assign mag_i      = instruction[31] ? (~field_i + 12'd1) : field_i;
    assign mag_s      = instruction[31] ? (~field_s + 12'd1) : field_s;
    assign mag_b      = instruction[31] ? (~field_b + 12'd1) : field_b;

    always_comb begin
        dec_legal  = 1'b0;
        dec_cls    = ClsAlu;
        dec_alusrc = 1'b0;
        dec_ctl    = 4'b0000;
        dec_branch = 1'b0;
        dec_neg    = 1'b0;
        dec_imm    = 12'd0;
        unique case (opcode)
            7'b0110011: begin
                dec_legal = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec_ctl = 4'b0010;
                    10'b0100000_000: dec_ctl = 4'b0110;
                    10'b0000000_111: dec_ctl = 4'b0000;
                    10'b0000000_110: dec_ctl = 4'b0001;
                    10'b0000000_100: dec_ctl = 4'b0100;
                    10'b0000000_101: dec_ctl = 4'b0101;
                    default:         dec_legal = 1'b0;
                endcase
            end
            7'b0010011, 7'b0000011: begin
                if (funct3 == (opcode[4] ? 3'b000 : 3'b010)) begin
                    dec_legal  = 1'b1;
                    dec_cls    = opcode[4] ? ClsAlu : ClsLoad;
                    dec_alusrc = 1'b1;
                    dec_ctl    = opcode[4] ? 4'b0011 : 4'b0010;
                    dec_neg    = instruction[31];
                    dec_imm    = mag_i;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    dec_legal  = 1'b1;
                    dec_cls    = ClsStore;
                    dec_alusrc = 1'b1;
                    dec_ctl    = 4'b0010;
                    dec_neg    = instruction[31];
                    dec_imm    = mag_s;
                end
            end
            7'b1100011: begin
                if (funct3[2:1] == 2'b00) begin
                    dec_legal  = 1'b1;
                    dec_cls    = ClsBranch;
                    dec_alusrc = 1'b1;
                    dec_branch = 1'b1;
                    dec_ctl    = funct3[0] ? 4'b1111 : 4'b0110;
                    dec_neg    = instruction[31];
                    dec_imm    = mag_b;
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StRstIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRstIdle: state_d = StFetch;
            StFetch:   state_d = StDecode;
            StDecode: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_d = dec_legal ? StExec : StTrap;
`else
                state_d = dec_legal ? StExec : StWbAlu;
`endif
            end
            StExec: begin
                unique case (cls_q)
                    ClsLoad:   state_d = StMemRd;
                    ClsStore:  state_d = StMemWr;
                    ClsBranch: state_d = StExecBr;
                    default:   state_d = StWbAlu;
                endcase
            end
            StExecBr:                            state_d = StBrRes;
            StMemRd:                             state_d = StWbMem;
            StWbAlu, StWbMem, StMemWr, StBrRes:  state_d = StFetch;
            StTrap:                              state_d = StTrap;
            default:                             state_d = StRstIdle;
        endcase
    end

    // Output logic: strobes follow the state being entered so they align with estado
    always_comb begin
        irwrite_d  = (state_d == StFetch);
        memread_d  = (state_d == StMemRd);
        memwrite_d = (state_d == StMemWr);
        memtoreg_d = (state_d == StWbMem);
        // WB_ALU entered straight from DECODE is an illegal-as-NOP retire: no register write
        regwrite_d = ((state_d == StWbAlu) && (state_q != StDecode)) || (state_d == StWbMem);
        pcwrite_d  = (state_d == StWbAlu) || (state_d == StWbMem) ||
                     (state_d == StMemWr) || (state_d == StBrRes);
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d  = (state_d == StTrap);
`else
        illegal_d  = (state_q == StDecode) && !dec_legal;
`endif
        instret_d  = instret_q + {{(INSTRET_W-1){1'b0}}, pcwrite_d};

        cls_d        = cls_q;
        alusrc_d     = alusrc_q;
        alucontrol_d = alucontrol_q;
        branch_d     = branch_q;
        negativo_d   = negativo_q;
        immediate_d  = immediate_q;
        if (state_q == StDecode) begin
            cls_d        = dec_cls;
            alusrc_d     = dec_alusrc;
            alucontrol_d = dec_ctl;
            branch_d     = dec_branch;
            negativo_d   = dec_neg;
            immediate_d  = dec_imm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cls_q        <= ClsAlu;
            alusrc_q     <= 1'b0;
            alucontrol_q <= 4'b0000;
            branch_q     <= 1'b0;
            negativo_q   <= 1'b0;
            immediate_q  <= 12'd0;
            irwrite_q    <= 1'b0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            pcwrite_q    <= 1'b0;
            illegal_q    <= 1'b0;
            instret_q    <= '0;
        end else begin
            cls_q        <= cls_d;
            alusrc_q     <= alusrc_d;
            alucontrol_q <= alucontrol_d;
            branch_q     <= branch_d;
            negativo_q   <= negativo_d;
            immediate_q  <= immediate_d;
            irwrite_q    <= irwrite_d;
            regwrite_q   <= regwrite_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            memtoreg_q   <= memtoreg_d;
            pcwrite_q    <= pcwrite_d;
            illegal_q    <= illegal_d;
            instret_q    <= instret_d;
        end
    end

    assign estado     = state_q;
    assign alusrc     = alusrc_q;
    assign alucontrol = alucontrol_q;
    assign branch     = branch_q;
    assign negativo   = negativo_q;
    assign immediate  = immediate_q;
    assign irwrite    = irwrite_q;
    assign regwrite   = regwrite_q;
    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign memtoreg   = memtoreg_q;
    assign pcwrite    = pcwrite_q;
    assign illegal    = illegal_q;
    assign instret    = instret_q;

endmodule
